// File: rtl/pdl_trig_cond.sv
// pdl_trig_cond: synchronises, glitch-filters and holdoff-gates a raw trigger for pdl; loads wb/dl only between triggers.
// Optional feature macro PDL_TRIG_CNT_EN adds trig_cnt/rej_cnt (accepted / holdoff-rejected trigger counts).
module pdl_trig_cond #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [WIDTH-1:0]  holdoff,
    input  logic [WIDTH-1:0]  wb_in,
    input  logic [WIDTH-1:0]  dl_in,
    input  logic              cfg_load,
    output logic              trigger,
    output logic [WIDTH-1:0]  wb,
    output logic [WIDTH-1:0]  dl,
    output logic              cfg_pending,
    output logic              busy
`ifdef PDL_TRIG_CNT_EN
    ,
    output logic [31:0]       trig_cnt,
    output logic [31:0]       rej_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_W-1:0] fcnt, flen;
    logic filt, filt_d, rise, fall, enter_idle;
    logic [WIDTH-1:0] hcnt, hcnt_nxt, wb_sh, dl_sh, wb_new;

    assign flen       = (filt_len == '0) ? FILT_W'(1) : filt_len;
    assign rise       = filt & ~filt_d;
    assign fall       = ~filt & filt_d;
    assign busy       = (state != IDLE);
    assign enter_idle = busy && (state_nxt == IDLE);
    assign wb_new     = (wb_in == '0) ? WIDTH'(1) : wb_in;

    // bring trig_in into the clk domain
    always_ff @(posedge clk or negedge reset)
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};

    // filt follows sync only after flen consecutive disagreeing cycles
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            fcnt   <= '0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            filt_d <= filt;
            if (sync_q[SYNC_STAGES-1] == filt) fcnt <= '0;
            else if (fcnt + 1'b1 == flen) begin
                fcnt <= '0;
                filt <= ~filt;
            end else fcnt <= fcnt + 1'b1;
        end

    // next state: accept rises only from IDLE, then hold off for the programmed cycles
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        case (state)
            IDLE:    if (rise) state_nxt = ACTIVE;
            ACTIVE:  if (fall) begin
                state_nxt = (holdoff == '0) ? IDLE : HOLDOFF;
                hcnt_nxt  = holdoff;
            end
            HOLDOFF: begin
                hcnt_nxt = hcnt - 1'b1;
                if (hcnt == WIDTH'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, registered trigger level and holdoff counter
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            trigger <= 1'b0;
            hcnt    <= '0;
        end else begin
            state   <= state_nxt;
            trigger <= (state_nxt == ACTIVE);
            hcnt    <= hcnt_nxt;
        end

    // wb/dl load directly when idle or on return to idle; otherwise park in the shadow
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wb          <= WIDTH'(1);
            dl          <= WIDTH'(1);
            wb_sh       <= WIDTH'(1);
            dl_sh       <= WIDTH'(1);
            cfg_pending <= 1'b0;
        end else begin
            if (cfg_load) begin
                wb_sh <= wb_new;
                dl_sh <= dl_in;
            end
            if (!busy || enter_idle) begin
                cfg_pending <= 1'b0;
                if (cfg_load) begin
                    wb <= wb_new;
                    dl <= dl_in;
                end else if (cfg_pending) begin
                    wb <= wb_sh;
                    dl <= dl_sh;
                end
            end else if (cfg_load) cfg_pending <= 1'b1;
        end

`ifdef PDL_TRIG_CNT_EN
    // count accepted triggers and rises swallowed by holdoff
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            trig_cnt <= '0;
            rej_cnt  <= '0;
        end else begin
            if (state == IDLE && rise)    trig_cnt <= trig_cnt + 1'b1;
            if (state == HOLDOFF && rise) rej_cnt  <= rej_cnt + 1'b1;
        end
`endif
endmodule

// File: tb/tb_pdl_trig_cond.sv
// tb_pdl_trig_cond: table-driven, directed and randomized checks of pdl_trig_cond against a behavioural model
`timescale 1ns/1ps
module tb_pdl_trig_cond;
    logic clk = 1'b0, reset = 1'b0, trig_in = 1'b0, cfg_load = 1'b0;
    logic [7:0] filt_len = 8'd1;
    logic [31:0] holdoff = '0, wb_in = '0, dl_in = '0;
    logic trigger, cfg_pending, busy;
    logic [31:0] wb, dl;
`ifdef PDL_TRIG_CNT_EN
    logic [31:0] trig_cnt, rej_cnt;
`endif
    int n_vec = 0, n_err = 0, rises = 0;
    bit chk_en = 1'b0, trig_prev = 1'b0;

    pdl_trig_cond dut (
        .clk(clk), .reset(reset), .trig_in(trig_in), .filt_len(filt_len),
        .holdoff(holdoff), .wb_in(wb_in), .dl_in(dl_in), .cfg_load(cfg_load),
        .trigger(trigger), .wb(wb), .dl(dl), .cfg_pending(cfg_pending), .busy(busy)
`ifdef PDL_TRIG_CNT_EN
        , .trig_cnt(trig_cnt), .rej_cnt(rej_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: the filter toggles once the last flen synchronised samples all
    // disagree with it; a trigger is accepted on a filtered rise only after the holdoff
    // window that started at the previous trigger's fall has fully elapsed.
    bit hist[$];
    bit m_filt, m_filt_d, m_trig, m_busy, m_pend;
    int m_n, m_hold_end, m_acc, m_rej;
    logic [31:0] m_wb, m_dl, m_swb, m_sdl;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist.delete();
            m_filt = 0; m_filt_d = 0; m_trig = 0; m_busy = 0; m_pend = 0;
            m_n = 0; m_hold_end = -1; m_acc = 0; m_rej = 0;
            m_wb = 1; m_dl = 1; m_swb = 1; m_sdl = 1;
        end else begin : step
            int flen;
            bit all_diff, rise, fall, was_busy, v;
            m_n++;
            flen = (filt_len == 0) ? 1 : int'(filt_len);
            all_diff = 1;
            for (int k = 0; k < flen; k++) begin
                v = (hist.size() > k + 1) ? hist[k + 1] : 1'b0;
                if (v == m_filt) all_diff = 0;
            end
            rise = m_filt & ~m_filt_d;
            fall = ~m_filt & m_filt_d;
            was_busy = m_busy;
            if (m_trig) begin
                if (fall) begin
                    m_trig = 0;
                    m_hold_end = m_n + int'(holdoff);
                end
            end else if (rise) begin
                if (m_n > m_hold_end) begin
                    m_trig = 1;
                    m_acc++;
                end else m_rej++;
            end
            m_busy = m_trig || (m_n < m_hold_end);
            if (!was_busy || !m_busy) begin
                if (cfg_load) begin
                    m_wb = (wb_in == 0) ? 32'd1 : wb_in;
                    m_dl = dl_in;
                end else if (m_pend) begin
                    m_wb = m_swb;
                    m_dl = m_sdl;
                end
                m_pend = 0;
            end else if (cfg_load) begin
                m_swb = (wb_in == 0) ? 32'd1 : wb_in;
                m_sdl = dl_in;
                m_pend = 1;
            end
            m_filt_d = m_filt;
            if (all_diff) m_filt = ~m_filt;
            hist.push_front(trig_in);
            if (hist.size() > 300) void'(hist.pop_back());
        end
    end

    // compare against the model mid-cycle and count trigger rises
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_trigger", trigger, m_trig);
            check("m_wb", wb, m_wb);
            check("m_dl", dl, m_dl);
            check("m_pending", cfg_pending, m_pend);
            check("m_busy", busy, m_busy);
`ifdef PDL_TRIG_CNT_EN
            check("m_trig_cnt", trig_cnt, m_acc);
            check("m_rej_cnt", rej_cnt, m_rej);
`endif
        end
        if (trigger && !trig_prev) rises++;
        trig_prev = trigger;
    end

    task automatic tick(int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(logic [31:0] w, logic [31:0] d);
        wb_in = w;
        dl_in = d;
        cfg_load = 1;
        tick();
        cfg_load = 0;
    endtask

    typedef struct {int fl; int ho; int l1; int gap; int l2; int exp_trigs;} vec_t;
    vec_t tbl[12];

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat_r, lat_f, r0, run;
        tbl = '{'{4, 0, 3, 0, 0, 0}, '{4, 0, 4, 0, 0, 1},
                '{3, 10, 20, 5, 20, 1}, '{3, 10, 20, 10, 20, 1},
                '{3, 10, 20, 11, 20, 2}, '{3, 10, 20, 12, 20, 2},
                '{0, 0, 1, 0, 0, 1}, '{0, 0, 2, 1, 2, 2},
                '{2, 3, 5, 1, 5, 1}, '{1, 3, 5, 3, 5, 1},
                '{1, 3, 5, 4, 5, 2}, '{1, 5, 5, 2, 30, 1}};
        chk_en = 1;
        for (int i = 0; i < 10; i++) begin
            trig_in = ~trig_in;
            tick();
            check("rst_trigger", trigger, 0);
            check("rst_wb", wb, 1);
            check("rst_dl", dl, 1);
            check("rst_busy", busy, 0);
        end
        trig_in = 0;
        reset = 1;
        tick(10);
        filt_len = 3;
        holdoff = 0;
        trig_in = 1;
        lat_r = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (trigger && lat_r == 0) lat_r = k;
        end
        trig_in = 0;
        lat_f = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!trigger && lat_f == 0) lat_f = k;
        end
        check("latency_rise", lat_r, 6);
        check("latency_fall", lat_f, 6);
        tick(10);
        foreach (tbl[i]) begin
            filt_len = tbl[i].fl[7:0];
            holdoff = tbl[i].ho;
            tick(2);
            r0 = rises;
            trig_in = 1;
            tick(tbl[i].l1);
            trig_in = 0;
            if (tbl[i].l2 > 0) begin
                tick(tbl[i].gap);
                trig_in = 1;
                tick(tbl[i].l2);
                trig_in = 0;
            end
            tick(60);
            check($sformatf("row%0d_triggers", i), rises - r0, tbl[i].exp_trigs);
        end
        filt_len = 1;
        holdoff = 4;
        trig_in = 1;
        for (int k = 0; k < 10 && !trigger; k++) tick();
        load(2, 2);
        check("defer_wb", wb, 1);
        check("defer_dl", dl, 1);
        check("defer_pending", cfg_pending, 1);
        trig_in = 0;
        for (int k = 0; k < 40 && busy; k++) tick();
        check("defer_idle", busy, 0);
        check("defer_wb_applied", wb, 2);
        check("defer_dl_applied", dl, 2);
        check("defer_pending_clr", cfg_pending, 0);
        load(0, 0);
        check("wb_zero_as_one", wb, 1);
        check("dl_zero", dl, 0);
        holdoff = 50;
        trig_in = 1;
        tick(6);
        trig_in = 0;
        tick(6);
        load(7, 7);
        check("midrst_pending_pre", cfg_pending, 1);
        check("midrst_busy_pre", busy, 1);
        #2;
        reset = 0;
        #1;
        check("midrst_trigger", trigger, 0);
        check("midrst_wb", wb, 1);
        check("midrst_dl", dl, 1);
        check("midrst_pending", cfg_pending, 0);
        check("midrst_busy", busy, 0);
        tick(2);
        reset = 1;
        tick(5);
        run = 0;
        for (int s = 0; s < 6; s++) begin
            filt_len = 8'($urandom_range(0, 5));
            holdoff = $urandom_range(0, 12);
            for (int c = 0; c < 400; c++) begin
                if (run == 0) begin
                    trig_in = ~trig_in;
                    run = $urandom_range(1, 9);
                end
                run--;
                cfg_load = ($urandom_range(0, 7) == 0);
                wb_in = $urandom_range(0, 3);
                dl_in = $urandom_range(0, 3);
                tick();
            end
            cfg_load = 0;
            trig_in = 0;
            run = 0;
            tick(40);
        end
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
